// File: rtl/roll_pkg.sv
// roll_pkg: FSM state codes, preset messages and digit sizing for the rolling display
package roll_pkg;
    localparam int DIGITS = 8;
    localparam int CODE_W = 4;
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t LOAD   = 2'd1;
    localparam state_t SCROLL = 2'd2;
    localparam state_t HOLD   = 2'd3;
    localparam logic [31:0] PRESET0 = 32'h00012334;
    localparam logic [31:0] PRESET1 = 32'h00000015;
    localparam logic [31:0] PRESET2 = 32'h00001616;
    localparam logic [31:0] PRESET3 = 32'h00012126;
    function automatic logic [31:0] preset(input logic [1:0] s);
        return s == 2'd0 ? PRESET0 : s == 2'd1 ? PRESET1 : s == 2'd2 ? PRESET2 : PRESET3;
    endfunction
endpackage

// File: rtl/roll_ctrl_tick_prescaler.sv
// tick_prescaler: counts 0..DIV-1 while en, pulses tick on the last count and wraps
// ports: clk, nCLR (sync active-low), en (count enable), clr (sync clear), tick (one-cycle pulse)
module tick_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic nCLR,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    // gated by en so a frozen counter parked at DIV-1 does not emit a stream of ticks
    assign tick = en && cnt == W'(DIV - 1);
    always_ff @(posedge clk)
        if (!nCLR || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/roll_ctrl.sv
// roll_ctrl: loads a preset 8-digit message, rotates it one digit per step, holds after each revolution, scans digits
// ports: clk, nCLR (sync active-low reset), set (load request, rising edge), sel (preset select),
//        pause (freeze rotation), dir (0 left, 1 right), AN (active-low digit enable), code (scanned digit code),
//        busy (not IDLE), S (scan index)
// option: PAUSE_BLINK_EN blanks the display on alternate step periods while paused
module roll_ctrl
    import roll_pkg::*;
#(
    parameter int SCAN_DIV   = 104166,
    parameter int STEP_DIV   = 25000000,
    parameter int HOLD_STEPS = 8
) (
    input  logic       clk,
    input  logic       nCLR,
    input  logic       set,
    input  logic [1:0] sel,
    input  logic       pause,
    input  logic       dir,
    output logic [7:0] AN,
    output logic [3:0] code,
    output logic       busy,
    output logic [2:0] S
);
    localparam int HW = $clog2(HOLD_STEPS + 1);
    state_t state;
    logic [1:0] sel_l;
    logic [31:0] msg;
    logic [2:0] step_cnt;
    logic [HW-1:0] hold_cnt;
    logic set_q, set_rise, scan_tick, step_tick, moving, run, hold_last;
    assign set_rise = set & ~set_q;
    assign busy = state != IDLE;
    assign moving = state == SCROLL || state == HOLD;
    assign run = moving && !pause;
    assign hold_last = hold_cnt == HW'(HOLD_STEPS - 1);
    assign code = msg[CODE_W*S +: CODE_W];
    tick_prescaler #(.DIV(SCAN_DIV)) u_scan (
        .clk(clk), .nCLR(nCLR), .en(busy), .clr(1'b0), .tick(scan_tick)
    );
    // cleared during LOAD so the first rotation lands a full step period after the load
    tick_prescaler #(.DIV(STEP_DIV)) u_step (
        .clk(clk), .nCLR(nCLR), .en(run), .clr(state == LOAD), .tick(step_tick)
    );
`ifdef PAUSE_BLINK_EN
    logic blink, pause_q, pause_rise, blink_tick;
    assign pause_rise = pause & ~pause_q;
    tick_prescaler #(.DIV(STEP_DIV)) u_blink (
        .clk(clk), .nCLR(nCLR), .en(1'b1), .clr(pause_rise), .tick(blink_tick)
    );
    always_ff @(posedge clk)
        if (!nCLR) begin
            blink   <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause;
            blink   <= pause_rise ? 1'b0 : blink ^ blink_tick;
        end
    assign AN = !busy || (moving && pause && blink) ? 8'hFF : ~(8'b1 << S);
`else
    assign AN = busy ? ~(8'b1 << S) : 8'hFF;
`endif
    // set_rise is tested first so a reload always beats a same-cycle step tick
    always_ff @(posedge clk)
        if (!nCLR) begin
            state    <= IDLE;
            sel_l    <= '0;
            msg      <= '0;
            S        <= '0;
            step_cnt <= '0;
            hold_cnt <= '0;
            set_q    <= 1'b0;
        end else begin
            set_q <= set;
            if (scan_tick) S <= S + 3'd1;
            if (set_rise) begin
                state <= LOAD;
                sel_l <= sel;
            end else if (state == LOAD) begin
                msg      <= preset(sel_l);
                step_cnt <= '0;
                hold_cnt <= '0;
                state    <= SCROLL;
            end else if (state == SCROLL && step_tick) begin
                msg      <= dir ? {msg[3:0], msg[31:4]} : {msg[27:0], msg[31:28]};
                step_cnt <= step_cnt + 3'd1;
                if (step_cnt == 3'd7) state <= HOLD;
            end else if (state == HOLD && step_tick) begin
                hold_cnt <= hold_last ? '0 : hold_cnt + 1'b1;
                if (hold_last) state <= SCROLL;
            end
        end
endmodule

// File: tb/tb_roll_ctrl.sv
// tb_roll_ctrl: directed stimulus with a cycle-stamped scoreboard checked by a separate monitor
module tb_roll_ctrl;
    localparam int K_AN = 0, K_CODE = 1, K_BUSY = 2, K_S = 3, K_MSG = 4, K_ST = 5, K_STEP = 6, K_HOLD = 7;
    localparam logic [31:0] ST_IDLE = 0, ST_LOAD = 1, ST_SCROLL = 2, ST_HOLD = 3;
    typedef struct {
        int cyc;
        int kind;
        logic [31:0] val;
    } exp_t;
    logic clk = 0, nCLR = 0, set = 0, pause = 0, dir = 0;
    logic [1:0] sel = 0;
    logic [7:0] AN;
    logic [3:0] code;
    logic busy;
    logic [2:0] S;
    int cyc = 0, tests = 0, fails = 0;
    exp_t q[$];
    exp_t x;
    logic [31:0] act;
    roll_ctrl #(.SCAN_DIV(4), .STEP_DIV(16), .HOLD_STEPS(2)) dut (
        .clk(clk), .nCLR(nCLR), .set(set), .sel(sel), .pause(pause), .dir(dir),
        .AN(AN), .code(code), .busy(busy), .S(S)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [31:0] actual(input int k);
        case (k)
            K_AN:    return {24'b0, AN};
            K_CODE:  return {28'b0, code};
            K_BUSY:  return {31'b0, busy};
            K_S:     return {29'b0, S};
            K_MSG:   return dut.msg;
            K_ST:    return {30'b0, dut.state};
            K_STEP:  return {29'b0, dut.step_cnt};
            default: return 32'(dut.hold_cnt);
        endcase
    endfunction
    function automatic string nm(input int k);
        case (k)
            K_AN:    return "AN";
            K_CODE:  return "code";
            K_BUSY:  return "busy";
            K_S:     return "S";
            K_MSG:   return "msg";
            K_ST:    return "state";
            K_STEP:  return "step_cnt";
            default: return "hold_cnt";
        endcase
    endfunction
    always @(negedge clk)
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            x = q.pop_front();
            act = actual(x.kind);
            tests++;
            if (act !== x.val) begin
                fails++;
                $display("FAIL %s @cycle %0d: got %h, expected %h", nm(x.kind), x.cyc, act, x.val);
            end
        end
    task automatic e(input int k, input logic [31:0] v);
        q.push_back('{cyc, k, v});
    endtask
    task automatic to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        to(1);
        set = 1;
        to(2);
        e(K_AN, 8'hFF); e(K_CODE, 0); e(K_BUSY, 0); e(K_S, 0); e(K_ST, ST_IDLE);
        set = 0;
        to(3);
        nCLR = 1;
        to(5);
        e(K_AN, 8'hFF); e(K_BUSY, 0);
        set = 1; sel = 0;
        to(6);
        e(K_ST, ST_LOAD); e(K_BUSY, 1);
        set = 0;
        to(7);
        e(K_AN, 8'hFE); e(K_CODE, 4'h4); e(K_MSG, 32'h00012334); e(K_ST, ST_SCROLL);
        to(11);
        e(K_S, 1); e(K_CODE, 4'h3); e(K_AN, 8'hFD);
        to(22);
        e(K_MSG, 32'h00012334);
        to(23);
        e(K_MSG, 32'h00123340); e(K_STEP, 1);
        dir = 1;
        to(39);
        e(K_MSG, 32'h00012334); e(K_STEP, 2);
        to(55);
        e(K_MSG, 32'h40001233); e(K_STEP, 3);
        set = 1; sel = 0; dir = 0;
        to(56);
        e(K_ST, ST_LOAD); e(K_MSG, 32'h40001233);
        set = 0;
        to(57);
        e(K_MSG, 32'h00012334); e(K_STEP, 0); e(K_ST, ST_SCROLL);
        to(73);
        e(K_MSG, 32'h00123340);
        to(184);
        e(K_MSG, 32'h40001233); e(K_STEP, 7); e(K_ST, ST_SCROLL);
        to(185);
        e(K_MSG, 32'h00012334); e(K_ST, ST_HOLD); e(K_STEP, 0);
        to(216);
        e(K_MSG, 32'h00012334); e(K_ST, ST_HOLD); e(K_HOLD, 1);
        to(217);
        e(K_ST, ST_SCROLL); e(K_MSG, 32'h00012334); e(K_HOLD, 0);
        to(232);
        e(K_MSG, 32'h00012334);
        to(233);
        e(K_MSG, 32'h00123340); e(K_STEP, 1);
        to(238);
        e(K_S, 2);
        pause = 1;
        to(288);
        e(K_MSG, 32'h00123340); e(K_STEP, 1); e(K_S, 6);
`ifndef PAUSE_BLINK_EN
        e(K_AN, 8'hBF);
`endif
        pause = 0;
        to(298);
        e(K_MSG, 32'h00123340);
        to(299);
        e(K_MSG, 32'h01233400); e(K_STEP, 2);
        to(395);
        e(K_MSG, 32'h00012334); e(K_ST, ST_HOLD);
        to(410);
        set = 1; sel = 3;
        to(411);
        e(K_ST, ST_LOAD); e(K_HOLD, 0); e(K_MSG, 32'h00012334);
        sel = 1;
        to(412);
        e(K_MSG, 32'h00012126); e(K_STEP, 0); e(K_ST, ST_SCROLL);
        set = 0;
        to(428);
        e(K_MSG, 32'h00121260); e(K_STEP, 1);
        nCLR = 0;
        to(429);
        e(K_AN, 8'hFF); e(K_BUSY, 0); e(K_ST, ST_IDLE); e(K_MSG, 0); e(K_S, 0); e(K_CODE, 0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations still pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
